// File: rtl/ldpc_phase_scheduler_if.sv
// Handshake and sweep bundle between the LDPC phase scheduler and its controller/processing units.
// The scheduler attaches through the slave modport.
interface ldpc_phase_scheduler_if;
   logic       start;
   logic       stall;
   logic       syn_valid;
   logic       syn_ok;
   logic [9:0] addr;
   logic       addr_valid;
   logic       cn_phase;
   logic [3:0] iter;
   logic       busy;
   logic       done;
   logic       converged;

   modport master (
      output start, stall, syn_valid, syn_ok,
      input  addr, addr_valid, cn_phase, iter, busy, done, converged
   );

   modport slave (
      input  start, stall, syn_valid, syn_ok,
      output addr, addr_valid, cn_phase, iter, busy, done, converged
   );
endinterface

// File: rtl/ldpc_phase_scheduler.sv
// Iteration/phase sequencer for the GF16 NB-LDPC decoder: CN sweep, drain, VN sweep, drain,
// syndrome check, repeated until convergence or the iteration limit.
//
// state | meaning
// IDLE  | waiting for start
// PRIME | issue first sweep address (preload 0x3FE + 2 wraps to 0)
// RUN   | issue remaining addresses in +2 steps, held by stall
// DRAIN | PIPE_LAT cycles for the processing pipeline to empty
// CHECK | wait for syndrome result
// DONE  | one-cycle done pulse
module ldpc_phase_scheduler #(
   parameter int NUM_ROWS = 384,
   parameter int MAX_ITER = 10,
   parameter int PIPE_LAT = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   ldpc_phase_scheduler_if.slave  bus
);
   localparam logic [9:0] ADDR_PRELOAD = 10'h3FE;
   localparam logic [9:0] ROWS_N       = 10'(NUM_ROWS);
   localparam logic [3:0] DRAIN_LAST   = 4'(PIPE_LAT - 1);
   localparam logic [3:0] ITER_LAST    = 4'(MAX_ITER - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_CHECK, S_DONE
   } state_t;

   state_t     r_state,      w_state;
   logic [9:0] r_addr,       w_addr;
   logic       r_addr_valid, w_addr_valid;
   logic       r_cn_phase,   w_cn_phase;
   logic [3:0] r_iter,       w_iter;
   logic       r_busy,       w_busy;
   logic       r_done,       w_done;
   logic       r_converged,  w_converged;
   logic [9:0] r_issued,     w_issued;
   logic [3:0] r_drain,      w_drain;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_addr_valid <= 1'b0;
         r_cn_phase   <= 1'b1;
         r_iter       <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_converged  <= 1'b0;
         r_issued     <= '0;
         r_drain      <= '0;
      end else begin
         r_state      <= w_state;
         r_addr       <= w_addr;
         r_addr_valid <= w_addr_valid;
         r_cn_phase   <= w_cn_phase;
         r_iter       <= w_iter;
         r_busy       <= w_busy;
         r_done       <= w_done;
         r_converged  <= w_converged;
         r_issued     <= w_issued;
         r_drain      <= w_drain;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_addr       = r_addr;
      w_addr_valid = 1'b0;
      w_cn_phase   = r_cn_phase;
      w_iter       = r_iter;
      w_busy       = r_busy;
      w_done       = 1'b0;
      w_converged  = r_converged;
      w_issued     = r_issued;
      w_drain      = r_drain;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state     = S_PRIME;
               w_cn_phase  = 1'b1;
               w_iter      = '0;
               w_converged = 1'b0;
               w_busy      = 1'b1;
               w_addr      = ADDR_PRELOAD;
            end
         end
         S_PRIME: begin
            w_addr       = r_addr + 10'd2;
            w_addr_valid = 1'b1;
            w_issued     = 10'd1;
            w_state      = S_RUN;
         end
         S_RUN: begin
            // A stalled edge issues nothing; addr and issued simply hold.
            if (!bus.stall) begin
               if (r_issued == ROWS_N) begin
                  w_drain = '0;
                  w_state = S_DRAIN;
               end else begin
                  w_addr       = r_addr + 10'd2;
                  w_addr_valid = 1'b1;
                  w_issued     = r_issued + 10'd1;
               end
            end
         end
         S_DRAIN: begin
            w_drain = r_drain + 4'd1;
            if (r_drain == DRAIN_LAST) begin
               if (r_cn_phase) begin
                  w_cn_phase = 1'b0;
                  w_addr     = ADDR_PRELOAD;
                  w_state    = S_PRIME;
               end else begin
                  w_state = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (bus.syn_valid) begin
               if (bus.syn_ok) begin
                  w_converged = 1'b1;
                  w_done      = 1'b1;
                  w_state     = S_DONE;
               end else if (r_iter == ITER_LAST) begin
                  w_converged = 1'b0;
                  w_done      = 1'b1;
                  w_state     = S_DONE;
               end else begin
                  w_iter     = r_iter + 4'd1;
                  w_cn_phase = 1'b1;
                  w_addr     = ADDR_PRELOAD;
                  w_state    = S_PRIME;
               end
            end
         end
         S_DONE: begin
            w_busy  = 1'b0;
            w_state = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase
   end

   assign bus.addr       = r_addr;
   assign bus.addr_valid = r_addr_valid;
   assign bus.cn_phase   = r_cn_phase;
   assign bus.iter       = r_iter;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.converged  = r_converged;
endmodule

// File: tb/tb_ldpc_phase_scheduler.sv
// Bench for ldpc_phase_scheduler: sweep-level reference model checked every cycle, directed
// scenarios with literal expectations, and a NUM_ROWS=512 address-width run.
module tb_ldpc_phase_scheduler;
   localparam int S_ROWS = 4;
   localparam int S_PIPE = 2;
   localparam int S_MAX  = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   ldpc_phase_scheduler_if sif ();
   ldpc_phase_scheduler_if bif ();

   ldpc_phase_scheduler #(.NUM_ROWS(S_ROWS), .MAX_ITER(S_MAX), .PIPE_LAT(S_PIPE)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif.slave)
   );

   ldpc_phase_scheduler #(.NUM_ROWS(512), .MAX_ITER(1), .PIPE_LAT(1)) u_big (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;
   int ek       = 0;

   // Reference model: expected outputs after each rising edge.
   logic [9:0] m_addr;
   bit         m_valid, m_cn, m_busy, m_done, m_conv, m_abort;
   logic [3:0] m_iter;

   task automatic m_reset_vals();
      m_addr = '0; m_valid = 0; m_cn = 1; m_iter = '0;
      m_busy = 0; m_done = 0; m_conv = 0;
   endtask

   task automatic tick();
      @(posedge clk or posedge reset);
      if (reset) begin
         m_reset_vals();
         m_abort = 1'b1;
      end
   endtask

   task automatic model_decode();
      m_abort = 0;
      m_busy = 1; m_conv = 0; m_done = 0; m_valid = 0;
      for (int it = 0; it < S_MAX; it++) begin
         m_iter = 4'(it);
         for (int ph = 0; ph < 2; ph++) begin
            m_cn   = (ph == 0);
            m_addr = 10'h3FE;
            tick(); if (m_abort) return;
            m_addr = 10'd0; m_valid = 1;
            for (int k = 1; k <= S_ROWS; k++) begin
               do begin
                  tick(); if (m_abort) return;
                  if (sif.stall) m_valid = 0;
               end while (sif.stall);
               if (k < S_ROWS) begin
                  m_addr = 10'(2 * k); m_valid = 1;
               end else begin
                  m_valid = 0;
               end
            end
            for (int d = 0; d < S_PIPE; d++) begin
               tick(); if (m_abort) return;
            end
         end
         do begin
            tick(); if (m_abort) return;
         end while (!sif.syn_valid);
         if (sif.syn_ok || it == S_MAX - 1) begin
            m_conv = sif.syn_ok;
            m_done = 1;
            break;
         end
      end
      tick(); if (m_abort) return;
      m_done = 0; m_busy = 0;
   endtask

   initial begin
      m_reset_vals();
      m_abort = 0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) m_reset_vals();
         else if (sif.start && !m_busy) model_decode();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_checks++;
         if ({sif.addr, sif.addr_valid, sif.cn_phase, sif.iter, sif.busy, sif.done, sif.converged} ===
             {m_addr, m_valid, m_cn, m_iter, m_busy, m_done, m_conv})
            n_pass++;
         else
            $display("FAIL cycle_model t=%0t dut addr=%h v=%b cn=%b it=%0d busy=%b done=%b conv=%b required addr=%h v=%b cn=%b it=%0d busy=%b done=%b conv=%b",
                     $time, sif.addr, sif.addr_valid, sif.cn_phase, sif.iter, sif.busy, sif.done, sif.converged,
                     m_addr, m_valid, m_cn, m_iter, m_busy, m_done, m_conv);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s got %0d required %0d", name, act, exp);
   endtask

   task automatic start_pulse();
      @(negedge clk);
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      ek = 0;
   endtask

   task automatic adv(input int k);
      while (ek < k) begin
         @(negedge clk);
         ek++;
      end
   endtask

   int  b_cnt, b_last, b_done_edge;
   bit  b_vn_seen;

   initial begin
      sif.start = 0; sif.stall = 0; sif.syn_valid = 0; sif.syn_ok = 0;
      bif.start = 0; bif.stall = 0; bif.syn_valid = 0; bif.syn_ok = 0;
      #1 reset = 1'b1;
      #2 chk_en = 1'b1;
      chk("rst_addr", sif.addr, 0);
      chk("rst_busy", sif.busy, 0);
      chk("rst_cn", sif.cn_phase, 1);
      chk("rst_iter", sif.iter, 0);
      chk("rst_valid", sif.addr_valid, 0);
      chk("rst_done", sif.done, 0);
      chk("rst_conv", sif.converged, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // basic sweep, converges on first check
      start_pulse();
      chk("t1_busy_e0", sif.busy, 1);
      adv(1);  chk("t1_cn_a0", sif.addr, 0);  chk("t1_cn_v0", sif.addr_valid, 1); chk("t1_cn_ph", sif.cn_phase, 1);
      adv(4);  chk("t1_cn_a3", sif.addr, 6);  chk("t1_cn_v3", sif.addr_valid, 1);
      adv(5);  chk("t1_drain_v", sif.addr_valid, 0);
      adv(8);  chk("t1_vn_a0", sif.addr, 0);  chk("t1_vn_v0", sif.addr_valid, 1); chk("t1_vn_ph", sif.cn_phase, 0);
      adv(11); chk("t1_vn_a3", sif.addr, 6);  chk("m_t1_vn_a3", m_addr, 6);
      adv(14); chk("t1_check_busy", sif.busy, 1); chk("t1_check_v", sif.addr_valid, 0);
      sif.syn_valid = 1; sif.syn_ok = 1;
      adv(15); chk("t1_done", sif.done, 1); chk("t1_conv", sif.converged, 1); chk("t1_iter", sif.iter, 0);
      chk("m_t1_done", m_done, 1);
      sif.syn_valid = 0; sif.syn_ok = 0;
      adv(16); chk("t1_done_clr", sif.done, 0); chk("t1_idle_busy", sif.busy, 0); chk("t1_conv_hold", sif.converged, 1);
      adv(18);

      // iteration limit: syndrome never satisfied
      sif.syn_valid = 1; sif.syn_ok = 0;
      start_pulse();
      chk("t2_conv_clr", sif.converged, 0);
      adv(15); chk("t2_iter1", sif.iter, 1); chk("t2_cn_again", sif.cn_phase, 1); chk("t2_not_done", sif.done, 0);
      adv(16); chk("t2_i1_a0", sif.addr, 0); chk("t2_i1_v0", sif.addr_valid, 1);
      adv(30); chk("t2_done", sif.done, 1); chk("t2_conv", sif.converged, 0); chk("t2_iter", sif.iter, 1);
      chk("m_t2_iter", m_iter, 1);
      adv(31); chk("t2_idle", sif.busy, 0);
      adv(33);

      // stall: 3 cycles on addr 2, 1 cycle on sweep exit, stall in DRAIN ignored
      sif.syn_valid = 1; sif.syn_ok = 1;
      start_pulse();
      adv(2); chk("t3_a1", sif.addr, 2); sif.stall = 1;
      adv(3); chk("t3_s1_v", sif.addr_valid, 0); chk("t3_s1_a", sif.addr, 2);
      adv(5); chk("t3_s3_v", sif.addr_valid, 0); chk("t3_s3_a", sif.addr, 2); sif.stall = 0;
      adv(6); chk("t3_a2", sif.addr, 4); chk("t3_a2_v", sif.addr_valid, 1);
      adv(7); chk("t3_a3", sif.addr, 6); sif.stall = 1;
      adv(8); chk("t3_exit_held", sif.addr_valid, 0); sif.stall = 0;
      adv(9); sif.stall = 1;
      adv(11); sif.stall = 0;
      adv(12); chk("t3_vn_a0", sif.addr, 0); chk("t3_vn_ph", sif.cn_phase, 0);
      adv(19); chk("t3_done", sif.done, 1); chk("t3_conv", sif.converged, 1);
      adv(22);
      sif.syn_valid = 0; sif.syn_ok = 0;

      // ignored start in RUN/CHECK, ignored syn_valid in DRAIN
      start_pulse();
      adv(2);  sif.start = 1;
      adv(3);  sif.start = 0;
      adv(5);  sif.syn_valid = 1; sif.syn_ok = 0;
      adv(7);  sif.syn_valid = 0;
      adv(8);  chk("t4_vn_start", sif.cn_phase, 0); chk("t4_iter", sif.iter, 0);
      adv(12); sif.syn_valid = 1; sif.syn_ok = 0;
      adv(14); sif.syn_ok = 1; sif.start = 1;
      adv(15); chk("t4_done", sif.done, 1); chk("t4_iter_end", sif.iter, 0); chk("t4_conv", sif.converged, 1);
      sif.syn_valid = 0; sif.syn_ok = 0; sif.start = 0;
      adv(17); chk("t4_idle", sif.busy, 0);

      // asynchronous reset during iteration 1 VN sweep
      sif.syn_valid = 1; sif.syn_ok = 0;
      start_pulse();
      adv(24); chk("t5_pre_a", sif.addr, 2); chk("t5_pre_it", sif.iter, 1); chk("t5_pre_ph", sif.cn_phase, 0);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_addr", sif.addr, 0);
      chk("t5_rst_busy", sif.busy, 0);
      chk("t5_rst_cn", sif.cn_phase, 1);
      chk("t5_rst_iter", sif.iter, 0);
      chk("t5_rst_valid", sif.addr_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      sif.syn_ok = 1;
      start_pulse();
      adv(1);  chk("t5_re_a0", sif.addr, 0); chk("t5_re_v0", sif.addr_valid, 1); chk("t5_re_it", sif.iter, 0);
      adv(15); chk("t5_re_done", sif.done, 1); chk("t5_re_conv", sif.converged, 1);
      adv(17);
      sif.syn_valid = 0; sif.syn_ok = 0;

      // width boundary with NUM_ROWS=512, PIPE_LAT=1, MAX_ITER=1
      @(negedge clk);
      bif.start = 1; bif.syn_valid = 1; bif.syn_ok = 0;
      @(negedge clk);
      bif.start = 0;
      b_cnt = 0; b_last = -1; b_done_edge = -1; b_vn_seen = 0;
      for (int e = 1; e <= 1100 && b_done_edge < 0; e++) begin
         @(negedge clk);
         if (bif.addr_valid && bif.cn_phase) begin
            chk("big_cn_addr", bif.addr, 2 * b_cnt);
            b_last = bif.addr;
            b_cnt++;
         end
         if (bif.addr_valid && !bif.cn_phase && !b_vn_seen) begin
            b_vn_seen = 1;
            chk("big_vn_first", bif.addr, 0);
         end
         if (bif.done) b_done_edge = e;
      end
      chk("big_cn_count", b_cnt, 512);
      chk("big_cn_last", b_last, 1022);
      chk("big_vn_seen", b_vn_seen, 1);
      chk("big_done_edge", b_done_edge, 1029);
      chk("big_conv", bif.converged, 0);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
